serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Parametrised, multi-cycle, digit-serial subtractor that computes DIFF = A − B − BIN, processing DIGIT bits per clock, LSB digit first.
- A mode input selects fixed subtrahend 1 (decrementer) or a general operand B.
- Sits in the ALU datapath as the next-generation full-subtractor/decrement unit. It trades latency for a single DIGIT-wide subtract cell with a registered borrow chain.

Parameters:
- WIDTH, 8, operand and result width in bits.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on a rising edge of clk when accepted
- mode  input  1  0: subtrahend = b; 1: subtrahend = 1 (b ignored)
- a  input  WIDTH  minuend; captured at accepted start
- b  input  WIDTH  subtrahend; captured at accepted start
- bin  input  1  borrow in; captured at accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle completion pulse
- diff  output  WIDTH  registered result
- bout  output  1  borrow out of the MSB; 1 when a < subtrahend + bin, unsigned
- zero  output  1  high when diff == 0
- ovf  output  1  signed (two's-complement) overflow of a − subtrahend − bin

Behaviour:
- Definitions: N = WIDTH/DIGIT. States: IDLE, RUN, DONE.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - busy = 0, done = 0, diff = 0, bout = 0, zero = 0, ovf = 0.
  - Internal shift registers, borrow register and digit counter are cleared.
- Accept: start is accepted when the state is IDLE or DONE (back-to-back operation allowed).
  - On acceptance, capture a, the subtrahend (b, or WIDTH'd1 when mode = 1) and bin.
  - The borrow register takes the value of bin. The counter is set to 0. State goes to RUN.
- start in RUN is ignored; captured operands are unaffected.
- RUN, on each edge:
  - Subtract the low DIGIT bits of the operand shift registers using the borrow register.
  - Shift the DIGIT result bits into the MSB end of the result shift register, and shift both operands right by DIGIT.
  - Update the borrow register to the borrow out of the digit.
  - Increment the counter. On the edge that processes digit N−1, go to DONE.
- Outputs in RUN: busy = 1 for the whole RUN state.
- Result update: diff, bout, zero and ovf are updated only on the edge that enters DONE. They hold the previous result throughout RUN.
- Flag definitions:
  - bout = final borrow.
  - zero = (diff == 0).
  - ovf = (a[MSB] != sub[MSB]) & (diff[MSB] != a[MSB]), where sub is the captured subtrahend. Compute it from operand MSBs captured at start.
- DONE: done = 1 for exactly one cycle, busy = 0. The next edge goes to IDLE, or to RUN if start = 1.
- Latency: start sampled on edge 0 → done high in the cycle between edges N and N+1. Example: WIDTH = 8, DIGIT = 1 gives N = 8.
- Arithmetic:
  - Each bit cell computes d = m ^ s ^ br and br' = (~m & s) | (~m & br) | (s & br).
  - In mode 1 the LSB cell reduces to d = ~(m ^ br), br' = ~m | br.
  - All arithmetic is modulo 2^WIDTH; no sign extension.
- Wrap-around:
  - 0 − 1 → all ones, bout = 1.
  - The most negative value minus 1 → most positive value, ovf = 1.
- Simultaneous reset and start: reset wins.
- Reset mid-RUN aborts the operation and no done pulse is produced.

Test Plan:
- WIDTH=8, DIGIT=1, mode=0, a=8'h05, b=8'h03, bin=0 → done 8 cycles after start; diff=8'h02, bout=0, zero=0, ovf=0; busy high for 8 cycles.
- mode=1, a=8'h00, bin=0 → diff=8'hFF, bout=1, ovf=0. Then mode=1, a=8'h80 → diff=8'h7F, bout=0, ovf=1.
- mode=0, a=8'h10, b=8'h10, bin=1 → diff=8'hFF, bout=1. Then bin=0 → diff=8'h00, zero=1, bout=0.
- WIDTH=16, DIGIT=4, a=16'h1234, b=16'h0235 → done 4 cycles after start; diff=16'h0FFF, bout=0. Pulse start again during RUN with other operands → ignored; result unchanged.
- Back-to-back: assert start in the DONE cycle with a=8'h09, b=8'h09 → second done exactly N+1 cycles after the first; diff=8'h00, zero=1.
- Assert rst asynchronously mid-RUN (cycle 3) → all outputs 0 immediately, no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial DIFF = A - SUB - BIN, DIGIT bits per clock, LSB digit first.
// Latency: start sampled on edge 0, done pulses in the cycle after edge N (N = WIDTH/DIGIT).
// Backpressure: none; start is accepted only in IDLE or DONE and is ignored while busy.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, mode     request; mode=1 substitutes a subtrahend of 1 for b
//   a, b, bin       minuend, subtrahend, borrow-in (captured when start is accepted)
//   busy, done      busy for the whole run; done is a one-cycle completion pulse
//   diff, bout      registered result and MSB borrow-out
//   zero, ovf       diff == 0, and signed overflow of the subtraction
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] s_sh_q,   s_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             a_msb_q,  a_msb_d;
    logic             s_msb_q,  s_msb_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;

    logic [WIDTH-1:0] sub_sel;
    logic [WIDTH-1:0] res_nxt;
    logic             br_c;

    // In decrement mode the subtrahend is simply the constant 1; the generic
    // bit cell then degenerates to the decrementer equations on its own.
    assign sub_sel = mode ? WIDTH'(1) : b;

    // One DIGIT-wide subtract cell: ripple the borrow through the low DIGIT
    // bits and drop each result bit into the top of the shifted result.
    always_comb begin
        br_c    = borrow_q;
        res_nxt = res_sh_q >> DIGIT;
        for (int i = 0; i < DIGIT; i++) begin
            res_nxt[WIDTH-DIGIT+i] = a_sh_q[i] ^ s_sh_q[i] ^ br_c;
            br_c = (~a_sh_q[i] & s_sh_q[i]) | (~a_sh_q[i] & br_c) | (s_sh_q[i] & br_c);
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        s_sh_d   = s_sh_q;
        res_sh_d = res_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        s_msb_d  = s_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                s_sh_d   = s_sh_q >> DIGIT;
                res_sh_d = res_nxt;
                borrow_d = br_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    diff_d  = res_nxt;
                    bout_d  = br_c;
                    zero_d  = (res_nxt == '0);
                    // Overflow only possible when operand signs differ and the
                    // result sign disagrees with the minuend.
                    ovf_d   = (a_msb_q != s_msb_q) & (res_nxt[WIDTH-1] != a_msb_q);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request, giving back-to-back runs.
                if (start) begin
                    state_d  = S_RUN;
                    a_sh_d   = a;
                    s_sh_d   = sub_sel;
                    res_sh_d = '0;
                    borrow_d = bin;
                    cnt_d    = '0;
                    a_msb_d  = a[WIDTH-1];
                    s_msb_d  = sub_sel[WIDTH-1];
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            s_sh_q   <= '0;
            res_sh_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            s_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            s_sh_q   <= s_sh_d;
            res_sh_q <= res_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            s_msb_q  <= s_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
    assign ovf  = ovf_q;

endmodule
